multicycle_cu: RTL
==================

# multicycle_cu

Multi-cycle control unit for the teaching MIPS core. It replaces the single-cycle opcode decoder with a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back. Memory accesses use a ready handshake with a parametrised timeout, and illegal opcodes trap. The unit sits between the instruction register opcode field, the memory port and the shared-ALU multi-cycle datapath.

## Interface
- OPW, 6, opcode width; opcode taken from ins[31:32-OPW]
- TIMEOUT, 0, max cycles waiting for mem_ready before trapping; 0 disables timeout
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPW  instruction opcode from IR (valid from DECODE onward)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_en  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 register A (jr)
- ir_write  out  1  load instruction register
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes, held until mem_ready
- mem_to_reg, reg_dst, r31, write_pc, reg_write  out  1 each  register-file write controls
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  2  00 funct, 01 add, 10 sub, 11 slt
- illegal  out  1  sticky trap flag
- trap_cause  out  1  0 illegal opcode, 1 memory timeout
- instr_done  out  1  one-cycle pulse on instruction retire
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Opcodes: 0 R-type, 1 lw, 2 sw, 3 addi, 4 slti, 5 j, 6 jal, 7 jr, 8 beq. Any other value is illegal.
- Moore outputs decode from the registered state; pc_en in BRANCH is gated by zero. Every output not listed for a state is 0.
- IDLE: all 0; next state FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=01.
  - On mem_ready: ir_write=1, pc_en=1, pc_src=00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=01 (branch target into ALUOut). Next state by opcode:
  - R-type -> EXEC_R
  - lw/sw -> ADDR
  - addi/slti -> EXEC_I
  - beq -> BRANCH
  - j -> JUMP, jal -> JAL, jr -> JR
  - illegal -> TRAP with trap_cause=0
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=00; next WB_R. WB_R: reg_write=1, reg_dst=1; retire.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=01; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready go to WB_MEM. WB_MEM: reg_write=1, mem_to_reg=1; retire.
- MEM_WR: mem_write=1, i_or_d=1; retire on mem_ready.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=01 (addi) or 11 (slti); next WB_I. WB_I: reg_write=1, reg_dst=0; retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=10, pc_src=01, pc_en=zero; retire.
- JUMP: pc_en=1, pc_src=10; retire.
- JAL: same as JUMP, plus reg_write=1, r31=1, write_pc=1 (PC already holds PC+4); retire.
- JR: pc_en=1, pc_src=11; retire.
- Retire: instr_done=1 in that cycle, instr_count increments, next state FETCH.
- TRAP: illegal=1; all strobes 0; absorbing until reset.
- Timeout: a wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle mem_ready=0. When TIMEOUT!=0 and the counter reaches TIMEOUT, the next state is TRAP with trap_cause=1. If mem_ready=1 arrives in the same cycle as the limit, mem_ready wins.

## Timing
- Reset: state IDLE; all outputs 0; instr_count=0; illegal=0; trap_cause=0. A reset asserted mid-instruction aborts it immediately and does not count it.
- First FETCH occurs on the 2nd rising edge after rst_n deasserts.
- Cycles per instruction with zero-wait memory (mem_ready=1 on first request cycle):
  - R, addi, slti, sw: 4
  - lw: 5
  - beq, j, jal, jr: 3
- Each cycle of mem_ready=0 adds one cycle.
- mem_read/mem_write remain asserted with a stable address until the mem_ready cycle inclusive.
- instr_count updates on the edge that ends the retire cycle; the wrap from all-ones to 0 is silent.

## Test plan
- Reset then R-type, mem_ready tied 1 -> states IDLE, FETCH, DECODE, EXEC_R, WB_R; instr_done in cycle 5; instr_count=1.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_read and i_or_d=1 held 4 cycles; WB_MEM asserts mem_to_reg=1, reg_write=1; total 8 cycles.
- beq with zero=0, then beq with zero=1 -> pc_en=0 then pc_en=1, pc_src=01; each takes 3 cycles.
- jal -> JAL cycle asserts reg_write=1, r31=1, write_pc=1, pc_en=1, pc_src=10; jr -> pc_src=11.
- opcode 6'h3F -> TRAP after DECODE; illegal=1, trap_cause=0; stays there with mem_ready toggling; cleared only by rst_n.
- TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles with trap_cause=1. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no trap. Reset asserted mid-lw -> all outputs 0 immediately; instr_count unchanged.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences fetch, decode, execute, memory and write-back,
// waits on mem_ready with an optional timeout, and traps on illegal opcodes.
module multicycle_cu #(
    parameter int unsigned OPW     = 6,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             r31,
    output logic             write_pc,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic             trap_cause,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_LW   = OPW'(1);
    localparam logic [OPW-1:0] OP_SW   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(3);
    localparam logic [OPW-1:0] OP_SLTI = OPW'(4);
    localparam logic [OPW-1:0] OP_J    = OPW'(5);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(6);
    localparam logic [OPW-1:0] OP_JR   = OPW'(7);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(8);

    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LIMIT = WW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM,
        MEM_WR, EXEC_I, WB_I, BRANCH, JUMP, JAL, JR, TRAP
    } state_t;

    state_t        state, nxt;
    logic [WW-1:0] wait_cnt;
    logic          op_sw, op_slti;
    logic          tmo_hit, trap_tmo;
    logic          waiting;

    // The limit is reached in the cycle that would be the TIMEOUT-th miss; a ready in that cycle still wins.
    assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign tmo_hit = (TIMEOUT != 0) && (wait_cnt == LIMIT) && !mem_ready;

    always_comb begin
        nxt        = state;
        trap_tmo   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        r31        = 1'b0;
        write_pc   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state)
            IDLE: nxt = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    nxt      = DECODE;
                end else if (tmo_hit) begin
                    nxt      = TRAP;
                    trap_tmo = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b01;
                case (opcode)
                    OP_R:             nxt = EXEC_R;
                    OP_LW, OP_SW:     nxt = ADDR;
                    OP_ADDI, OP_SLTI: nxt = EXEC_I;
                    OP_BEQ:           nxt = BRANCH;
                    OP_J:             nxt = JUMP;
                    OP_JAL:           nxt = JAL;
                    OP_JR:            nxt = JR;
                    default:          nxt = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                nxt       = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b01;
                nxt       = op_sw ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    nxt = WB_MEM;
                end else if (tmo_hit) begin
                    nxt      = TRAP;
                    trap_tmo = 1'b1;
                end
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end else if (tmo_hit) begin
                    nxt      = TRAP;
                    trap_tmo = 1'b1;
                end
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = op_slti ? 2'b11 : 2'b01;
                nxt       = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            JUMP: begin
                pc_en      = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            JAL: begin
                pc_en      = 1'b1;
                pc_src     = 2'b10;
                reg_write  = 1'b1;
                r31        = 1'b1;
                write_pc   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            JR: begin
                pc_en      = 1'b1;
                pc_src     = 2'b11;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            TRAP: illegal = 1'b1;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            op_sw       <= 1'b0;
            op_slti     <= 1'b0;
            trap_cause  <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= nxt;
            // Every exit from a wait state happens on mem_ready, so clearing on ready also clears on entry.
            if (waiting && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == DECODE) begin
                op_sw   <= (opcode == OP_SW);
                op_slti <= (opcode == OP_SLTI);
            end
            if (state != TRAP && nxt == TRAP) begin
                trap_cause <= trap_tmo;
            end
            if (instr_done) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule
